// File: rtl/zbt_pkg.sv
// Constants, address packing and FSM states shared by the ZBT frame-buffer
// clients (capture controller and row peak scanner).
package zbt_pkg;

  localparam int ZBT_DATA_W   = 36;
  localparam int ZBT_ADDR_W   = 19;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int ROW_W        = 10;
  localparam int WORD_W       = 8;
  localparam int LANE_W       = 2;
  localparam int LANES_W      = PIX_W * PIX_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EMIT
  } scan_state_e;

  // Row in the upper field, word in the lower field, MSB unused.
  function automatic logic [ZBT_ADDR_W-1:0] zbt_pack_addr(
    input logic [ROW_W-1:0]  row,
    input logic [WORD_W-1:0] word
  );
    return {1'b0, row, word};
  endfunction

endpackage

// File: rtl/zbt_row_peak_scanner_if.sv
// ZBT read port plus row-result handshake; master = scanner, slave = memory/consumer side.
interface zbt_row_peak_scanner_if;

  logic [zbt_pkg::ZBT_ADDR_W-1:0] zbt_read_addr;
  logic                           zbt_read_req;
  logic [zbt_pkg::ZBT_DATA_W-1:0] zbt_read_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [zbt_pkg::ROW_W-1:0]      out_row;
  logic [zbt_pkg::ROW_W-1:0]      out_col;
  logic [zbt_pkg::PIX_W-1:0]      out_peak;
  logic                           out_hit;

  modport master (
    output zbt_read_addr, zbt_read_req,
    output out_valid, out_row, out_col, out_peak, out_hit,
    input  zbt_read_data, out_ready
  );

  modport slave (
    input  zbt_read_addr, zbt_read_req,
    input  out_valid, out_row, out_col, out_peak, out_hit,
    output zbt_read_data, out_ready
  );

endinterface

// File: rtl/zbt_row_peak_scanner_word_max.sv
// Registered 4-lane max reduction of one ZBT word; lowest lane wins ties.
module zbt_word_max
  import zbt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               vld_p0,
  input  logic [WORD_W-1:0]  word_p0,
  input  logic [LANES_W-1:0] data_p0,
  output logic               vld_p1,
  output logic [WORD_W-1:0]  word_p1,
  output logic [PIX_W-1:0]   max_p1,
  output logic [LANE_W-1:0]  lane_p1
);

  function automatic logic [PIX_W+LANE_W-1:0] best_lane(input logic [LANES_W-1:0] d);
    logic [PIX_W-1:0]  m;
    logic [LANE_W-1:0] l;
    m = d[PIX_W-1:0];
    l = '0;
    for (int k = 1; k < PIX_PER_WORD; k++) begin
      if (d[k*PIX_W +: PIX_W] > m) begin
        m = d[k*PIX_W +: PIX_W];
        l = LANE_W'(k);
      end
    end
    return {m, l};
  endfunction

  logic               vld_d, vld_q;
  logic [WORD_W-1:0]  word_d, word_q;
  logic [PIX_W-1:0]   max_d, max_q;
  logic [LANE_W-1:0]  lane_d, lane_q;

  always_comb begin
    vld_d           = vld_p0;
    word_d          = word_p0;
    {max_d, lane_d} = best_lane(data_p0);
  end

  // p0 -> p1: only the valid bit is control, the rest is free-running data
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
    word_q <= word_d;
    max_q  <= max_d;
    lane_q <= lane_d;
  end

  assign vld_p1  = vld_q;
  assign word_p1 = word_q;
  assign max_p1  = max_q;
  assign lane_p1 = lane_q;

endmodule

// File: rtl/zbt_row_peak_scanner.sv
// Reads the ZBT frame back row by row and reports each row's brightest column
// over a valid/ready handshake; backpressure only between rows.
module zbt_row_peak_scanner
  import zbt_pkg::*;
#(
  parameter int         ROWS   = 480,
  parameter int         WORDS  = 180,
  parameter int         RD_LAT = 2,
  parameter logic [7:0] THRESH = 8'd32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   frame_done,
  zbt_row_peak_scanner_if.master zif
);

  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

  scan_state_e           state_d, state_q;
  logic [ROW_W-1:0]      row_d, row_q;
  logic [WORD_W-1:0]     word_d, word_q;
  logic [2:0]            drain_d, drain_q;
  logic [ZBT_ADDR_W-1:0] addr_d, addr_q;
  logic                  req_d, req_q;
  logic                  out_valid_d, out_valid_q;
  logic                  busy_d, busy_q;
  logic                  frame_done_d, frame_done_q;
  logic [PIX_W-1:0]      run_peak_d, run_peak_q;
  logic [ROW_W-1:0]      run_col_d, run_col_q;
  logic                  tag_vld_d [RD_LAT];
  logic                  tag_vld_q [RD_LAT];
  logic [WORD_W-1:0]     tag_word_d [RD_LAT];
  logic [WORD_W-1:0]     tag_word_q [RD_LAT];

  logic                  row_start;
  logic                  wm_vld;
  logic [WORD_W-1:0]     wm_word;
  logic [PIX_W-1:0]      wm_max;
  logic [LANE_W-1:0]     wm_lane;
  logic [PIX_W-1:0]      best_peak;
  logic [ROW_W-1:0]      best_col;
  logic [3:0]            unused_data_hi;

  assign unused_data_hi = zif.zbt_read_data[ZBT_DATA_W-1:LANES_W];

  // The reduction register is the last stage of read-latency alignment.
  zbt_word_max u_word_max (
    .clk     (clk),
    .reset   (reset),
    .vld_p0  (tag_vld_q[RD_LAT-1]),
    .word_p0 (tag_word_q[RD_LAT-1]),
    .data_p0 (zif.zbt_read_data[LANES_W-1:0]),
    .vld_p1  (wm_vld),
    .word_p1 (wm_word),
    .max_p1  (wm_max),
    .lane_p1 (wm_lane)
  );

  // Strictly-greater merge keeps the leftmost column on ties; the last word
  // of a row lands in the first EMIT cycle and is visible through this path.
  always_comb begin
    best_peak = run_peak_q;
    best_col  = run_col_q;
    if (wm_vld && (wm_max > run_peak_q)) begin
      best_peak = wm_max;
      best_col  = {wm_word, wm_lane};
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    word_d       = word_q;
    drain_d      = drain_q;
    req_d        = req_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    row_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          row_d     = '0;
          word_d    = '0;
          req_d     = 1'b1;
          busy_d    = 1'b1;
          row_start = 1'b1;
        end
      end
      ISSUE: begin
        if (word_q == LAST_WORD) begin
          state_d = DRAIN;
          req_d   = 1'b0;
          drain_d = '0;
        end else begin
          word_d = word_q + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      EMIT: begin
        if (zif.out_ready) begin
          out_valid_d = 1'b0;
          row_start   = 1'b1;
          if (row_q == LAST_ROW) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            row_d   = row_q + 10'd1;
            word_d  = '0;
            req_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    addr_d     = zbt_pack_addr(row_d, word_d);
    run_peak_d = row_start ? '0 : best_peak;
    run_col_d  = row_start ? '0 : best_col;

    tag_vld_d[0]  = req_q;
    tag_word_d[0] = word_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_word_d[i] = tag_word_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      word_q       <= '0;
      drain_q      <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      run_peak_q   <= '0;
      run_col_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_vld_q[i] <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      word_q       <= word_d;
      drain_q      <= drain_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      run_peak_q   <= run_peak_d;
      run_col_q    <= run_col_d;
      tag_vld_q    <= tag_vld_d;
    end
    tag_word_q <= tag_word_d;
  end

  assign zif.zbt_read_addr = addr_q;
  assign zif.zbt_read_req  = req_q;
  assign zif.out_valid     = out_valid_q;
  assign zif.out_row       = row_q;
  assign zif.out_col       = best_col;
  assign zif.out_peak      = best_peak;
  assign zif.out_hit       = (best_peak >= THRESH);
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_zbt_row_peak_scanner.sv
// Directed bench for zbt_row_peak_scanner: 3 rows x 4 words, read latency 2.
`timescale 1ns/1ps
module tb_zbt_row_peak_scanner;

  localparam int         ROWS   = 3;
  localparam int         WORDS  = 4;
  localparam int         RD_LAT = 2;
  localparam logic [7:0] THRESH = 8'd32;
  localparam logic [35:0] JUNK  = 36'hF_FEFE_FEFE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done;

  int n_checks = 0;
  int n_fail = 0;

  zbt_row_peak_scanner_if zif();

  zbt_row_peak_scanner #(
    .ROWS(ROWS), .WORDS(WORDS), .RD_LAT(RD_LAT), .THRESH(THRESH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .zif(zif)
  );

  always #5 clk = ~clk;

  // ZBT model: 16-entry store indexed {row[1:0], word[1:0]}, two-cycle latency,
  // junk on the bus whenever no live read was issued.
  logic [35:0] mem [16];
  logic [35:0] rd_p0 = JUNK;
  logic [35:0] rd_p1 = JUNK;
  always @(posedge clk) begin
    if (zif.zbt_read_req && zif.zbt_read_addr[18:10] == 9'd0 && zif.zbt_read_addr[9:8] != 2'd3
        && zif.zbt_read_addr[7:2] == 6'd0)
      rd_p0 <= mem[{zif.zbt_read_addr[9:8], zif.zbt_read_addr[1:0]}];
    else
      rd_p0 <= JUNK;
    rd_p1 <= rd_p0;
  end
  assign zif.zbt_read_data = rd_p1;

  int res_n, fd_n, fd_cyc, first_vld_cyc, acc0_cyc, addr_n, held, held_changed, held_req;
  logic busy_c0, busy_prev, busy_pre_fd, busy_at_fd;
  logic [9:0]  res_row [8];
  logic [9:0]  res_col [8];
  logic [7:0]  res_peak [8];
  logic        res_hit [8];
  logic [18:0] addr_log [32];
  int          addr_cyc [32];
  logic [9:0]  snap_col, snap_row;
  logic [7:0]  snap_peak;
  logic        snap_hit;

  task automatic fill_mem(input logic [35:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  // Runs one frame from a start pulse, logging results, addresses and timing.
  task automatic run_frame(input int hold, input int dup_cyc);
    res_n = 0; fd_n = 0; fd_cyc = -1; first_vld_cyc = -1; acc0_cyc = -1; addr_n = 0;
    held = 0; held_changed = 0; held_req = 0;
    busy_c0 = 1'b0; busy_prev = 1'b0; busy_pre_fd = 1'b0; busy_at_fd = 1'b1;
    zif.out_ready = (hold == 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 0) busy_c0 = busy;
      if (zif.zbt_read_req && addr_n < 32) begin
        addr_log[addr_n] = zif.zbt_read_addr;
        addr_cyc[addr_n] = cyc;
        addr_n++;
      end
      if (frame_done) begin
        fd_n++;
        if (fd_cyc < 0) begin
          fd_cyc = cyc; busy_at_fd = busy; busy_pre_fd = busy_prev;
        end
      end
      if (zif.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (zif.out_valid && !zif.out_ready) begin
        if (held == 0) begin
          snap_row = zif.out_row; snap_col = zif.out_col;
          snap_peak = zif.out_peak; snap_hit = zif.out_hit;
        end else if (zif.out_row !== snap_row || zif.out_col !== snap_col ||
                     zif.out_peak !== snap_peak || zif.out_hit !== snap_hit) begin
          held_changed = 1;
        end
        if (zif.zbt_read_req) held_req = 1;
        held++;
        if (held > hold) zif.out_ready = 1'b1;
      end
      if (zif.out_valid && zif.out_ready) begin
        if (res_n < 8) begin
          res_row[res_n] = zif.out_row; res_col[res_n] = zif.out_col;
          res_peak[res_n] = zif.out_peak; res_hit[res_n] = zif.out_hit;
        end
        res_n++;
        if (acc0_cyc < 0) acc0_cyc = cyc;
      end
      start = (cyc == dup_cyc);
      if (fd_cyc >= 0 && cyc >= fd_cyc + 6) break;
      busy_prev = busy;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_checks++; if (zif.zbt_read_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b expected 0", zif.zbt_read_req); end
    n_checks++; if (zif.zbt_read_addr !== 19'd0) begin n_fail++; $display("FAIL rst_addr: got %0h expected 0", zif.zbt_read_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (zif.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", zif.out_valid); end
    n_checks++; if ({zif.out_row, zif.out_col, zif.out_peak, zif.out_hit} !== 29'd0) begin
      n_fail++; $display("FAIL rst_result: got row %0d col %0d peak %0d hit %0b expected all 0",
                         zif.out_row, zif.out_col, zif.out_peak, zif.out_hit); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %0b expected 0", frame_done); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || zif.zbt_read_req !== 1'b0) begin
      n_fail++; $display("FAIL start_during_reset: got busy %0b req %0b expected 0 0", busy, zif.zbt_read_req); end
  endtask

  task automatic test_all_zero();
    fill_mem(36'hF_0000_0000);
    run_frame(0, -1);
    n_checks++; if (res_n !== 3) begin n_fail++; $display("FAIL zero_count: got %0d expected 3", res_n); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (res_row[r] !== 10'(r) || res_col[r] !== 10'd0 || res_peak[r] !== 8'd0 || res_hit[r] !== 1'b0) begin
        n_fail++; $display("FAIL zero_row%0d: got row %0d col %0d peak %0d hit %0b expected row %0d col 0 peak 0 hit 0",
                           r, res_row[r], res_col[r], res_peak[r], res_hit[r], r); end
    end
    n_checks++; if (fd_cyc !== 21) begin n_fail++; $display("FAIL zero_frame_done_cycle: got %0d expected 21", fd_cyc); end
    n_checks++; if (fd_n !== 1) begin n_fail++; $display("FAIL zero_frame_done_count: got %0d expected 1", fd_n); end
    n_checks++; if (first_vld_cyc !== 6) begin n_fail++; $display("FAIL zero_first_valid: got %0d expected 6", first_vld_cyc); end
    n_checks++; if (busy_c0 !== 1'b1 || busy_pre_fd !== 1'b1 || busy_at_fd !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: got c0 %0b pre %0b at_done %0b expected 1 1 0", busy_c0, busy_pre_fd, busy_at_fd); end
    n_checks++; if (addr_n !== 12) begin n_fail++; $display("FAIL zero_addr_count: got %0d expected 12", addr_n); end
    n_checks++; if (addr_cyc[4] !== 7 || addr_log[4] !== 19'h100) begin
      n_fail++; $display("FAIL zero_row1_first_addr: got %0h at %0d expected 100 at 7", addr_log[4], addr_cyc[4]); end
  endtask

  task automatic test_single_peak();
    int ec[3]; int ep[3]; logic eh[3];
    fill_mem(36'h0_0A0A_0A0A);
    mem[4*1+2] = 36'h0_C80A_0A0A;
    ec = '{0, 11, 0}; ep = '{10, 200, 10}; eh = '{1'b0, 1'b1, 1'b0};
    run_frame(0, -1);
    n_checks++; if (res_n !== 3) begin n_fail++; $display("FAIL peak_count: got %0d expected 3", res_n); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (res_row[r] !== 10'(r) || res_col[r] !== 10'(ec[r]) || res_peak[r] !== 8'(ep[r]) || res_hit[r] !== eh[r]) begin
        n_fail++; $display("FAIL peak_row%0d: got row %0d col %0d peak %0d hit %0b expected row %0d col %0d peak %0d hit %0b",
                           r, res_row[r], res_col[r], res_peak[r], res_hit[r], r, ec[r], ep[r], eh[r]); end
    end
  endtask

  task automatic test_ties();
    int ec[3]; int ep[3]; logic eh[3];
    fill_mem(36'h0);
    mem[4*0+1] = 36'h0_0000_5A00;
    mem[4*0+3] = 36'h0_0000_5A00;
    mem[4*1+2] = 36'h0_005A_5A00;
    mem[4*2+3] = 36'h0_0020_0000;
    ec = '{5, 9, 14}; ep = '{90, 90, 32}; eh = '{1'b1, 1'b1, 1'b1};
    run_frame(0, -1);
    n_checks++; if (res_n !== 3) begin n_fail++; $display("FAIL tie_count: got %0d expected 3", res_n); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (res_row[r] !== 10'(r) || res_col[r] !== 10'(ec[r]) || res_peak[r] !== 8'(ep[r]) || res_hit[r] !== eh[r]) begin
        n_fail++; $display("FAIL tie_row%0d: got row %0d col %0d peak %0d hit %0b expected row %0d col %0d peak %0d hit %0b",
                           r, res_row[r], res_col[r], res_peak[r], res_hit[r], r, ec[r], ep[r], eh[r]); end
    end
  endtask

  task automatic load_pattern_d();
    fill_mem(36'h0);
    mem[4*0+0] = 36'h0_0000_0032;
    mem[4*1+3] = 36'h0_FF00_0000;
    mem[4*2+1] = 36'h0_0000_001F;
  endtask

  task automatic check_pattern_d(input string tag);
    int ec[3]; int ep[3]; logic eh[3];
    ec = '{0, 15, 4}; ep = '{50, 255, 31}; eh = '{1'b1, 1'b1, 1'b0};
    n_checks++; if (res_n !== 3) begin n_fail++; $display("FAIL %s_count: got %0d expected 3", tag, res_n); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (res_row[r] !== 10'(r) || res_col[r] !== 10'(ec[r]) || res_peak[r] !== 8'(ep[r]) || res_hit[r] !== eh[r]) begin
        n_fail++; $display("FAIL %s_row%0d: got row %0d col %0d peak %0d hit %0b expected row %0d col %0d peak %0d hit %0b",
                           tag, r, res_row[r], res_col[r], res_peak[r], res_hit[r], r, ec[r], ep[r], eh[r]); end
    end
  endtask

  task automatic test_backpressure();
    load_pattern_d();
    run_frame(5, -1);
    check_pattern_d("hold");
    n_checks++; if (acc0_cyc !== 11) begin n_fail++; $display("FAIL hold_accept_cycle: got %0d expected 11", acc0_cyc); end
    n_checks++; if (held_changed !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d changes expected 0", held_changed); end
    n_checks++; if (held_req !== 0) begin n_fail++; $display("FAIL hold_req: got %0d expected 0", held_req); end
    for (int w = 0; w < 4; w++) begin
      n_checks++; if (addr_log[4+w] !== 19'(256 + w) || addr_cyc[4+w] !== 12 + w) begin
        n_fail++; $display("FAIL hold_addr%0d: got %0h at %0d expected %0h at %0d",
                           w, addr_log[4+w], addr_cyc[4+w], 256 + w, 12 + w); end
    end
    n_checks++; if (fd_cyc !== 26) begin n_fail++; $display("FAIL hold_frame_done_cycle: got %0d expected 26", fd_cyc); end
  endtask

  task automatic test_reset_mid_frame();
    load_pattern_d();
    zif.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || zif.zbt_read_req !== 1'b0 || zif.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_drain: got busy %0b req %0b valid %0b expected 1 0 0", busy, zif.zbt_read_req, zif.out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || zif.zbt_read_req !== 1'b0 || zif.out_valid !== 1'b0 || frame_done !== 1'b0 ||
                    zif.zbt_read_addr !== 19'd0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got busy %0b req %0b valid %0b done %0b addr %0h expected all 0",
                         busy, zif.zbt_read_req, zif.out_valid, frame_done, zif.zbt_read_addr); end
    n_checks++; if ({zif.out_row, zif.out_col, zif.out_peak, zif.out_hit} !== 29'd0) begin
      n_fail++; $display("FAIL mid_reset_result: got row %0d col %0d peak %0d hit %0b expected all 0",
                         zif.out_row, zif.out_col, zif.out_peak, zif.out_hit); end
    repeat (2) @(negedge clk);
    n_checks++; if (zif.out_peak !== 8'd0 || zif.out_col !== 10'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_late_data: got peak %0d col %0d busy %0b expected 0 0 0", zif.out_peak, zif.out_col, busy); end
    run_frame(0, -1);
    check_pattern_d("rescan");
    n_checks++; if (fd_cyc !== 21) begin n_fail++; $display("FAIL rescan_frame_done_cycle: got %0d expected 21", fd_cyc); end
  endtask

  task automatic test_start_while_busy();
    fill_mem(36'h0_0A0A_0A0A);
    mem[4*1+2] = 36'h0_C80A_0A0A;
    run_frame(0, 3);
    n_checks++; if (addr_n !== 12) begin n_fail++; $display("FAIL busy_addr_count: got %0d expected 12", addr_n); end
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (addr_log[i] !== 19'((i / 4) * 256 + (i % 4)) || addr_cyc[i] !== (i / 4) * 7 + (i % 4)) begin
        n_fail++; $display("FAIL busy_addr%0d: got %0h at %0d expected %0h at %0d",
                           i, addr_log[i], addr_cyc[i], (i / 4) * 256 + (i % 4), (i / 4) * 7 + (i % 4)); end
    end
    n_checks++; if (res_n !== 3) begin n_fail++; $display("FAIL busy_result_count: got %0d expected 3", res_n); end
    n_checks++; if (fd_n !== 1 || fd_cyc !== 21) begin
      n_fail++; $display("FAIL busy_frame_done: got %0d pulses at %0d expected 1 at 21", fd_n, fd_cyc); end
    n_checks++; if (res_col[1] !== 10'd11 || res_peak[1] !== 8'd200) begin
      n_fail++; $display("FAIL busy_row1: got col %0d peak %0d expected 11 200", res_col[1], res_peak[1]); end
  endtask

  initial begin
    zif.out_ready = 1'b1;
    fill_mem(36'h0);
    test_reset();
    test_all_zero();
    test_single_peak();
    test_ties();
    test_backpressure();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
